fir_mac_scheduler: RTL

Time-multiplexed controller for the fixed-point FIR datapath. It uses one shared multiply-accumulate unit across all No_coeff taps.
- Accepts one input sample per handshake, shifts it into a sample delay line, then runs No_coeff MAC cycles.
- Presents Filt_Out with a per-result overFlow flag.
- Owns the coefficient register bank, written through a port-side write interface (no hierarchical $readmemb into the filter).

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 48 ++++
 rtl/fir_mac_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths, state encoding and helpers for the time-multiplexed FIR MAC scheduler.
package fir_pkg;

  // Ceiling log2. Never returns 0, so the result can always size an index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  localparam int unsigned NoCoeffDef   = 8;
  localparam int unsigned WI1Def       = 4;
  localparam int unsigned WF1Def       = 5;
  localparam int unsigned WICDef       = 4;
  localparam int unsigned WFCDef       = 5;
  localparam int unsigned FiltOrderDef = 4;

  localparam int unsigned SampleW = WI1Def + WF1Def;
  localparam int unsigned CoeffW  = WICDef + WFCDef;
  localparam int unsigned ProdW   = SampleW + CoeffW;
  // One extra bit above the output width exposes overflow as a sign mismatch.
  localparam int unsigned AccW    = WI1Def + WICDef + FiltOrderDef + WF1Def + WFCDef + 1;
  localparam int unsigned TapW    = clog2(NoCoeffDef);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMac  = 1'b1
  } fir_state_e;

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate: registered accumulator with clear, add enable and sticky overflow.
module fir_mac_unit import fir_pkg::*; #(
  parameter int unsigned ProdWidth = ProdW,
  parameter int unsigned AccWidth  = AccW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [ProdWidth-1:0] prod_i,
  output logic        [AccWidth-2:0]  res_o,
  output logic                        ovf_o
);

  logic signed [AccWidth-1:0] acc_q, acc_d, sum;
  logic                       ovf_q, ovf_d, step_ovf;

  assign sum      = acc_q + AccWidth'(prod_i);
  assign step_ovf = sum[AccWidth-1] ^ sum[AccWidth-2];
  // Result and flag already include the product being added this cycle.
  assign res_o    = sum[AccWidth-2:0];
  assign ovf_o    = ovf_q | step_ovf;

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      acc_d = sum;
      ovf_d = ovf_q | step_ovf;
    end
  end

  // Accumulator and sticky overflow registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller: owns delay line, coefficient bank and the IDLE/MAC sequencer around one MAC.
module fir_mac_scheduler import fir_pkg::*; #(
  parameter int unsigned No_coeff   = NoCoeffDef,
  parameter int unsigned WI1        = WI1Def,
  parameter int unsigned WF1        = WF1Def,
  parameter int unsigned WIC        = WICDef,
  parameter int unsigned WFC        = WFCDef,
  parameter int unsigned Filt_order = FiltOrderDef,
  parameter int unsigned WIO        = WI1 + WIC + Filt_order,
  parameter int unsigned WFO        = WF1 + WFC
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          coeff_wr_en,
  input  logic [clog2(No_coeff)-1:0]    coeff_wr_addr,
  input  logic [WIC+WFC-1:0]            coeff_wr_data,
  output logic                          coeff_wr_ready,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WI1+WF1-1:0]            input_sample,
  output logic                          out_valid,
  output logic [WIO+WFO-1:0]            Filt_Out,
  output logic                          overFlow,
  output logic                          busy
);

  localparam int unsigned SW = WI1 + WF1;
  localparam int unsigned CW = WIC + WFC;
  localparam int unsigned PW = SW + CW;
  localparam int unsigned OW = WIO + WFO;
  localparam int unsigned TW = clog2(No_coeff);
  localparam logic [TW-1:0] LastTap = TW'(No_coeff - 1);

  fir_state_e           state_q, state_d;
  logic [TW-1:0]        tap_q, tap_d;
  logic signed [SW-1:0] x_q [No_coeff];
  logic signed [CW-1:0] c_q [No_coeff];
  logic [OW-1:0]        filt_q;
  logic                 ovf_q, valid_q;
  logic                 accept, last, mac_clr, mac_en, wr_ok;
  logic signed [PW-1:0] prod;
  logic [OW-1:0]        mac_res;
  logic                 mac_ovf;

  assign in_ready       = (state_q == StIdle);
  assign coeff_wr_ready = (state_q == StIdle);
  assign busy           = (state_q == StMac);
  assign out_valid      = valid_q;
  assign Filt_Out       = filt_q;
  assign overFlow       = ovf_q;

  // Out-of-range taps only exist when No_coeff is not a power of two.
  assign wr_ok = coeff_wr_en && coeff_wr_ready && (32'(coeff_wr_addr) < No_coeff);
  assign prod  = PW'(x_q[tap_q]) * PW'(c_q[tap_q]);

  // Sequencer: accept a sample in IDLE, then one MAC per tap.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    accept  = 1'b0;
    last    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        tap_d  = tap_q + TW'(1);
        if (tap_q == LastTap) begin
          last    = 1'b1;
          tap_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and tap counter.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // Delay line shifts on accept; coefficient bank takes port writes only while idle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < int'(No_coeff); i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_q[0] <= input_sample;
        for (int i = 1; i < int'(No_coeff); i++) x_q[i] <= x_q[i-1];
      end
      if (wr_ok) c_q[coeff_wr_addr] <= coeff_wr_data;
    end
  end

  // Result registers: capture the final sum on the last tap, pulse out_valid once.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      filt_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= last;
      if (last) begin
        filt_q <= mac_res;
        ovf_q  <= mac_ovf;
      end
    end
  end

  fir_mac_unit #(
    .ProdWidth (PW),
    .AccWidth  (OW + 1)
  ) u_mac (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .prod_i (prod),
    .res_o  (mac_res),
    .ovf_o  (mac_ovf)
  );

endmodule
